// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage
//   Generic valid/ready pipeline stage carrying a WIDTH-bit payload, with
//   back-pressure and a synchronous flush (branch squash).
//   SKID=1: main + skid entries, registered in_ready, full throughput.
//   SKID=0: single entry, in_ready combinational from out_ready.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   flush      synchronous squash of all held entries
//   in_valid   upstream beat present on in_data
//   in_ready   stage can accept a beat this cycle
//   in_data    upstream payload
//   out_valid  out_data holds a valid beat
//   out_ready  downstream consumes out_data this cycle
//   out_data   registered payload to next stage (BUBBLE while empty)
//   level      number of entries held (0..2)
//
// State (level_q)
//   state    | meaning
//   ST_EMPTY | nothing held, out_data = BUBBLE
//   ST_ONE   | main entry valid, skid entry free
//   ST_FULL  | main and skid valid, upstream stalled (SKID=1 only)

module pipe_skid_stage #(
    parameter int               WIDTH  = 32,
    parameter int               SKID   = 1,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       level
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]       level_d,    level_q;
    logic [WIDTH-1:0] main_d,     main_q;
    logic [WIDTH-1:0] skid_d,     skid_q;
    logic             in_ready_d, in_ready_q;
    logic             accept;
    logic             consume;

    assign out_valid = (level_q != ST_EMPTY);
    // SKID=1 keeps in_ready purely registered so out_ready never reaches upstream
    assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;
    assign out_data  = main_q;
    assign level     = level_q;

    always_comb begin
        level_d = level_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (SKID != 0) begin
            case (level_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        level_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        main_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        level_d = ST_FULL;
                    end else if (consume) begin
                        main_d  = BUBBLE;
                        level_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready_q is low here, so no accept can coincide
                    if (consume) begin
                        main_d  = skid_q;
                        level_d = ST_ONE;
                    end
                end
                default: begin
                    main_d  = BUBBLE;
                    level_d = ST_EMPTY;
                end
            endcase
        end else begin
            if (accept) begin
                main_d  = in_data;
                level_d = ST_ONE;
            end else if (consume) begin
                main_d  = BUBBLE;
                level_d = ST_EMPTY;
            end
        end

        // flush wins over a same-cycle accept; a same-cycle consume was already delivered
        if (flush) begin
            main_d  = BUBBLE;
            level_d = ST_EMPTY;
        end

        in_ready_d = (level_d != ST_FULL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q    <= ST_EMPTY;
            main_q     <= BUBBLE;
            skid_q     <= BUBBLE;
            in_ready_q <= 1'b1;
        end else begin
            level_q    <= level_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb_pipe_skid_stage
//   Drives two instances side by side: index 0 with SKID=1, index 1 with SKID=0.
//   A queue per instance holds the beats expected downstream.

module tb_pipe_skid_stage;

    localparam logic [7:0] BUBBLE = 8'hEE;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush     [2];
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [7:0] in_data   [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [7:0] out_data  [2];
    logic [1:0] level     [2];

    logic [7:0] sbq0 [$];
    logic [7:0] sbq1 [$];

    int  n_chk = 0;
    int  n_err = 0;
    int  dlv [2];
    bit  acc_last [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pipe_skid_stage #(
            .WIDTH  (8),
            .SKID   (1 - g),
            .BUBBLE (BUBBLE)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g]),
            .level     (level[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? sbq0.size() : sbq1.size();
    endfunction

    function automatic logic [7:0] qfront(input int d);
        if (d == 0) return sbq0[0];
        return sbq1[0];
    endfunction

    task automatic qpush(input int d, input logic [7:0] v);
        if (d == 0) sbq0.push_back(v);
        else        sbq1.push_back(v);
    endtask

    task automatic qpop(input int d);
        if (d == 0) void'(sbq0.pop_front());
        else        void'(sbq1.pop_front());
    endtask

    task automatic qclear(input int d);
        if (d == 0) sbq0.delete();
        else        sbq1.delete();
    endtask

    // Check current outputs against the queues, then advance one clock edge.
    task automatic step();
        bit acc [2];
        bit cons [2];
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            int         sz;
            logic       exp_rdy;
            logic [7:0] exp_data;
            string      pre;
            sz       = qsize(d);
            pre      = $sformatf("d%0d_", d);
            exp_rdy  = (d == 0) ? (sz != 2) : ((sz == 0) || out_ready[d]);
            exp_data = BUBBLE;
            if (sz != 0) exp_data = qfront(d);
            check_eq({pre, "out_valid"}, 32'(out_valid[d]), 32'(sz != 0));
            check_eq({pre, "level"},     32'(level[d]),     32'(sz));
            check_eq({pre, "in_ready"},  32'(in_ready[d]),  32'(exp_rdy));
            check_eq({pre, "out_data"},  32'(out_data[d]),  32'(exp_data));
            acc[d]  = in_valid[d] && exp_rdy;
            cons[d] = (sz != 0) && out_ready[d];
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (cons[d]) begin
                qpop(d);
                dlv[d]++;
            end
            if (flush[d])    qclear(d);
            else if (acc[d]) qpush(d, in_data[d]);
            acc_last[d] = acc[d];
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [7:0] dat, input bit r, input bit f);
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = v;
            in_data[d]   = dat;
            out_ready[d] = r;
            flush[d]     = f;
        end
    endtask

    task automatic do_reset(input string tag);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        #2;
        for (int d = 0; d < 2; d++) begin
            string pre;
            pre = $sformatf("%s_d%0d_", tag, d);
            qclear(d);
            check_eq({pre, "out_valid"}, 32'(out_valid[d]), 32'd0);
            check_eq({pre, "level"},     32'(level[d]),     32'd0);
            check_eq({pre, "in_ready"},  32'(in_ready[d]),  32'd1);
            check_eq({pre, "out_data"},  32'(out_data[d]),  32'(BUBBLE));
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        dlv[0] = 0;
        dlv[1] = 0;
        acc_last[0] = 1'b0;
        acc_last[1] = 1'b0;

        // reset at t=0
        do_reset("rst0");

        // streaming, one beat per cycle
        drive(1'b1, 8'h11, 1'b1, 1'b0); step();
        check_eq("t2_first_data", 32'(out_data[0]), 32'h11);
        check_eq("t2_first_valid", 32'(out_valid[0]), 32'd1);
        drive(1'b1, 8'h22, 1'b1, 1'b0); step();
        drive(1'b1, 8'h33, 1'b1, 1'b0); step();
        check_eq("t2_last_data", 32'(out_data[1]), 32'h33);
        drive(1'b0, 8'h00, 1'b1, 1'b0); step(); step();

        // stall: fill main + skid, third beat held upstream
        drive(1'b1, 8'h0A, 1'b0, 1'b0); step();
        drive(1'b1, 8'h0B, 1'b0, 1'b0); step();
        drive(1'b1, 8'h0C, 1'b0, 1'b0); step();
        check_eq("t3_level", 32'(level[0]), 32'd2);
        check_eq("t3_in_ready", 32'(in_ready[0]), 32'd0);
        check_eq("t3_hold_data", 32'(out_data[0]), 32'h0A);
        drive(1'b1, 8'h0C, 1'b1, 1'b0); step();
        check_eq("t3_second", 32'(out_data[0]), 32'h0B);
        step();
        check_eq("t3_third", 32'(out_data[0]), 32'h0C);
        drive(1'b0, 8'h00, 1'b1, 1'b0); step(); step();

        // flush while full, incoming beat dropped
        drive(1'b1, 8'h01, 1'b0, 1'b0); step();
        drive(1'b1, 8'h02, 1'b0, 1'b0); step();
        drive(1'b1, 8'h0D, 1'b0, 1'b1); step();
        check_eq("t4_level", 32'(level[0]), 32'd0);
        check_eq("t4_valid", 32'(out_valid[0]), 32'd0);
        check_eq("t4_bubble", 32'(out_data[0]), 32'(BUBBLE));
        drive(1'b1, 8'h0E, 1'b1, 1'b0); step();
        check_eq("t4_next", 32'(out_data[0]), 32'h0E);
        drive(1'b0, 8'h00, 1'b1, 1'b0); step(); step();

        // single-entry replace in place
        drive(1'b1, 8'h44, 1'b1, 1'b0); step();
        drive(1'b1, 8'h55, 1'b1, 1'b0); step();
        check_eq("t5_data", 32'(out_data[1]), 32'h55);
        check_eq("t5_level", 32'(level[1]), 32'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b0); step(); step();

        // flush together with consume
        drive(1'b1, 8'h77, 1'b0, 1'b0); step();
        drive(1'b0, 8'h00, 1'b1, 1'b1); step();
        drive(1'b0, 8'h00, 1'b0, 1'b0); step();

        // reset mid-stream
        drive(1'b1, 8'h66, 1'b0, 1'b0); step();
        drive(1'b1, 8'h67, 1'b0, 1'b0); step();
        do_reset("rst_mid");
        step();

        // random traffic
        dlv[0] = 0;
        dlv[1] = 0;
        cyc    = 0;
        while ((dlv[0] < 10000 || dlv[1] < 10000) && cyc < 60000) begin
            for (int d = 0; d < 2; d++) begin
                if (!in_valid[d] || acc_last[d]) begin
                    in_valid[d] = ($urandom_range(0, 3) != 0);
                    in_data[d]  = 8'($urandom);
                end
                out_ready[d] = ($urandom_range(0, 3) != 0);
                flush[d]     = ($urandom_range(0, 199) == 0);
            end
            step();
            cyc++;
        end
        check_eq("rand_done_d0", 32'(dlv[0] >= 10000), 32'd1);
        check_eq("rand_done_d1", 32'(dlv[1] >= 10000), 32'd1);

        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step(); step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
